// File: rtl/cgra_kernel_dispatcher_pkg.sv
// Shared CGRA dispatch types: kernel-memory word layout, dispatcher FSM states and sizing constants.
package cgra_kernel_dispatcher_pkg;

  localparam int N_SLOTS        = 2;
  localparam int N_COL          = 4;
  localparam int KER_CONF_N_REG = 16;
  localparam int KER_ID_W       = $clog2(KER_CONF_N_REG);
  localparam int IMEM_N_LINES   = 128;
  localparam int IMEM_ADD_W     = $clog2(IMEM_N_LINES);
  localparam int RCS_NUM_CREG   = 32;
  localparam int N_INSTR_W      = $clog2(RCS_NUM_CREG);
  localparam int KMEM_W         = N_COL + IMEM_ADD_W + N_INSTR_W;
  localparam int COL_CNT_W      = $clog2(N_COL + 1);
  localparam int SLOT_W         = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef struct packed {
    logic [N_COL-1:0]      n_col_onehot;
    logic [IMEM_ADD_W-1:0] imem_add;
    logic [N_INSTR_W-1:0]  n_instr;
  } kmem_word_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_DECODE = 3'd2,
    ST_ALLOC  = 3'd3,
    ST_LAUNCH = 3'd4
  } dispatch_state_t;

  // One-hot bit k of the column field requests k+1 columns.
  function automatic logic [COL_CNT_W-1:0] onehot_to_cnt(input logic [N_COL-1:0] oh);
    logic [COL_CNT_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < N_COL; k++) begin
      cnt = oh[k] ? COL_CNT_W'(k + 1) : cnt;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/cgra_kernel_dispatcher_col_picker.sv
// Column picker: chooses need_i columns out of free_i. Define CGRA_DISPATCH_CONTIG_EN to require a
// contiguous run at the lowest fitting base; otherwise the lowest-index free columns are taken.
module cgra_col_picker
  import cgra_kernel_dispatcher_pkg::*;
(
  input  logic [N_COL-1:0]     free_i,
  input  logic [COL_CNT_W-1:0] need_i,
  output logic [N_COL-1:0]     sel_o,
  output logic                 ok_o
);

`ifdef CGRA_DISPATCH_CONTIG_EN
  // Scan bases upward; first window that fits entirely inside the array and is fully free wins.
  always_comb begin
    logic [N_COL-1:0] win;
    logic             fit;
    sel_o = '0;
    ok_o  = 1'b0;
    win   = '0;
    fit   = 1'b0;
    for (int b = 0; b < N_COL; b++) begin
      for (int k = 0; k < N_COL; k++) begin
        win[k] = (k >= b) && (k < b + int'(need_i));
      end
      fit   = (need_i != '0) && (b + int'(need_i) <= N_COL) && ((free_i & win) == win);
      sel_o = (fit && !ok_o) ? win : sel_o;
      ok_o  = ok_o | fit;
    end
  end
`else
  // Take free columns from index 0 upward until the request is covered.
  always_comb begin
    logic [COL_CNT_W-1:0] cnt;
    sel_o = '0;
    cnt   = '0;
    for (int k = 0; k < N_COL; k++) begin
      sel_o[k] = free_i[k] && (cnt < need_i);
      cnt      = cnt + COL_CNT_W'(sel_o[k]);
    end
    ok_o = (need_i != '0) && (cnt == need_i);
  end
`endif

endmodule

// File: rtl/cgra_kernel_dispatcher.sv
// Per-slot kernel launcher: reads the kernel config word, allocates RC columns, launches and tracks
// completion. Column placement policy depends on CGRA_DISPATCH_CONTIG_EN (see cgra_col_picker).
module cgra_kernel_dispatcher
  import cgra_kernel_dispatcher_pkg::*;
(
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [N_SLOTS-1:0]                 start_i,
  input  logic [N_SLOTS-1:0][KER_ID_W-1:0]   ker_id_i,
  output logic                               kmem_req_o,
  output logic [KER_ID_W-1:0]                kmem_addr_o,
  input  logic [KMEM_W-1:0]                  kmem_rdata_i,
  output logic [N_COL-1:0]                   col_start_o,
  output logic [IMEM_ADD_W-1:0]              col_imem_add_o,
  output logic [N_INSTR_W-1:0]               col_n_instr_o,
  input  logic [N_COL-1:0]                   col_done_i,
  output logic [N_SLOTS-1:0]                 slot_busy_o,
  output logic [N_SLOTS-1:0]                 slot_done_o,
  output logic [N_SLOTS-1:0]                 slot_err_o
);

  dispatch_state_t                 state_q, state_d;
  logic [N_SLOTS-1:0]              pend_q, pend_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [N_SLOTS-1:0][KER_ID_W-1:0] kid_q, kid_d;
  logic [N_SLOTS-1:0][N_COL-1:0]   own_q, own_d;
  logic [SLOT_W-1:0]               rr_q, rr_d, gnt_q, gnt_d;
  kmem_word_t                      word_q, word_d;
  logic [N_COL-1:0]                mask_q, mask_d;

  kmem_word_t       rd_s;
  logic [N_COL-1:0] free_s, pick_sel_s;
  logic             pick_ok_s;

  assign rd_s = kmem_word_t'(kmem_rdata_i);

  // Columns owned by no slot are allocatable.
  always_comb begin
    free_s = '1;
    for (int s = 0; s < N_SLOTS; s++) begin
      free_s = free_s & ~own_q[s];
    end
  end

  cgra_col_picker u_picker (
    .free_i (free_s),
    .need_i (onehot_to_cnt(word_q.n_col_onehot)),
    .sel_o  (pick_sel_s),
    .ok_o   (pick_ok_s)
  );

  // Slot bookkeeping, round-robin grant and dispatch FSM next state.
  always_comb begin
    logic              found;
    logic              hit;
    logic [SLOT_W-1:0] idx;
    logic [SLOT_W-1:0] sel;
    state_d = state_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    kid_d   = kid_q;
    own_d   = own_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    word_d  = word_q;
    mask_d  = mask_q;
    done_d  = '0;
    err_d   = '0;
    found   = 1'b0;
    hit     = 1'b0;
    idx     = '0;
    sel     = '0;

    // A start in the same cycle as that slot's done pulse is dropped via done_q.
    for (int s = 0; s < N_SLOTS; s++) begin
      own_d[s]  = own_q[s] & ~col_done_i;
      done_d[s] = (own_q[s] != '0) && (own_d[s] == '0);
      hit       = start_i[s] && !busy_q[s] && !done_q[s];
      busy_d[s] = (busy_q[s] && !done_d[s]) || hit;
      pend_d[s] = pend_q[s] || hit;
      kid_d[s]  = hit ? ker_id_i[s] : kid_q[s];
    end

    for (int i = 0; i < N_SLOTS; i++) begin
      idx   = SLOT_W'((int'(rr_q) + i) % N_SLOTS);
      hit   = pend_q[idx] && !found;
      sel   = hit ? idx : sel;
      found = found || hit;
    end

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d   = sel;
          rr_d    = SLOT_W'((int'(sel) + 1) % N_SLOTS);
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        word_d = rd_s;
        if ($onehot(rd_s.n_col_onehot)) begin
          state_d = ST_ALLOC;
        end else begin
          err_d[gnt_q]  = 1'b1;
          pend_d[gnt_q] = 1'b0;
          busy_d[gnt_q] = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      ST_ALLOC: begin
        if (pick_ok_s) begin
          mask_d  = pick_sel_s;
          state_d = ST_LAUNCH;
        end else begin
          state_d = ST_ALLOC;
        end
      end
      ST_LAUNCH: begin
        own_d[gnt_q]  = own_d[gnt_q] | mask_q;
        pend_d[gnt_q] = 1'b0;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
      kid_q   <= '0;
      own_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      word_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      kid_q   <= kid_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
    end
  end

  assign kmem_req_o     = (state_q == ST_READ);
  assign kmem_addr_o    = kmem_req_o ? kid_q[gnt_q] : '0;
  assign col_start_o    = (state_q == ST_LAUNCH) ? mask_q : '0;
  assign col_imem_add_o = (state_q == ST_LAUNCH) ? word_q.imem_add : '0;
  assign col_n_instr_o  = (state_q == ST_LAUNCH) ? word_q.n_instr : '0;
  assign slot_busy_o    = busy_q;
  assign slot_done_o    = done_q;
  assign slot_err_o     = err_q;

endmodule

// File: tb/tb_cgra_kernel_dispatcher.sv
// Scoreboard bench for cgra_kernel_dispatcher; expectations follow CGRA_DISPATCH_CONTIG_EN when defined.
module tb_cgra_kernel_dispatcher;
  import cgra_kernel_dispatcher_pkg::*;

  localparam int K_LAUNCH = 1;
  localparam int K_DONE   = 2;
  localparam int K_ERR    = 3;

  typedef struct {
    int                    kind;
    logic [N_COL-1:0]      val;
    logic [IMEM_ADD_W-1:0] add;
    logic [N_INSTR_W-1:0]  n;
    int                    cyc;
  } ev_t;

  logic                             clk_i = 1'b0;
  logic                             rst_ni;
  logic [N_SLOTS-1:0]               start_i;
  logic [N_SLOTS-1:0][KER_ID_W-1:0] ker_id_i;
  logic                             kmem_req_o;
  logic [KER_ID_W-1:0]              kmem_addr_o;
  logic [KMEM_W-1:0]                kmem_rdata_i;
  logic [N_COL-1:0]                 col_start_o;
  logic [IMEM_ADD_W-1:0]            col_imem_add_o;
  logic [N_INSTR_W-1:0]             col_n_instr_o;
  logic [N_COL-1:0]                 col_done_i;
  logic [N_SLOTS-1:0]               slot_busy_o, slot_done_o, slot_err_o;

  logic [KMEM_W-1:0] kmem [KER_CONF_N_REG];
  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  cgra_kernel_dispatcher dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .ker_id_i       (ker_id_i),
    .kmem_req_o     (kmem_req_o),
    .kmem_addr_o    (kmem_addr_o),
    .kmem_rdata_i   (kmem_rdata_i),
    .col_start_o    (col_start_o),
    .col_imem_add_o (col_imem_add_o),
    .col_n_instr_o  (col_n_instr_o),
    .col_done_i     (col_done_i),
    .slot_busy_o    (slot_busy_o),
    .slot_done_o    (slot_done_o),
    .slot_err_o     (slot_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Kernel memory answers one cycle after the request strobe.
  always @(posedge clk_i) begin
    if (kmem_req_o) kmem_rdata_i <= kmem[kmem_addr_o];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [N_COL-1:0] val, input logic [IMEM_ADD_W-1:0] add,
                      input logic [N_INSTR_W-1:0] n, input int at);
    ev_t e;
    e.kind = kind; e.val = val; e.add = add; e.n = n; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [N_COL-1:0] val, input logic [IMEM_ADD_W-1:0] add,
                          input logic [N_INSTR_W-1:0] n);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%b at cycle %0d, expected no event", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc ||
          (kind == K_LAUNCH && (e.add != add || e.n != n))) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%b add=%0h n=%0d cyc=%0d, expected kind=%0d val=%b add=%0h n=%0d cyc=%0d",
                 kind, val, add, n, cyc, e.kind, e.val, e.add, e.n, e.cyc);
      end
    end
  endtask

  // Monitor: every pulse the DUT presents must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (col_start_o != '0) check_ev(K_LAUNCH, col_start_o, col_imem_add_o, col_n_instr_o);
      if (slot_done_o != '0) check_ev(K_DONE, N_COL'(slot_done_o), '0, '0);
      if (slot_err_o != '0)  check_ev(K_ERR, N_COL'(slot_err_o), '0, '0);
      if ((slot_done_o & slot_err_o) != '0) chk("done_err_overlap", 32'(slot_done_o & slot_err_o), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk_i);
  endtask

  task automatic start(input logic [N_SLOTS-1:0] m, input logic [KER_ID_W-1:0] k0, input logic [KER_ID_W-1:0] k1);
    start_i = m; ker_id_i[0] = k0; ker_id_i[1] = k1;
    tick(1);
    start_i = '0;
  endtask

  task automatic cdone(input logic [N_COL-1:0] m);
    col_done_i = m;
    tick(1);
    col_done_i = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_kmem_req"}, 32'(kmem_req_o), 32'd0);
    chk({tag, "_kmem_addr"}, 32'(kmem_addr_o), 32'd0);
    chk({tag, "_col_start"}, 32'(col_start_o), 32'd0);
    chk({tag, "_imem_add"}, 32'(col_imem_add_o), 32'd0);
    chk({tag, "_n_instr"}, 32'(col_n_instr_o), 32'd0);
    chk({tag, "_busy"}, 32'(slot_busy_o), 32'd0);
    chk({tag, "_done"}, 32'(slot_done_o), 32'd0);
    chk({tag, "_err"}, 32'(slot_err_o), 32'd0);
  endtask

  initial begin
    int c;
    int c0;
    for (int i = 0; i < KER_CONF_N_REG; i++) kmem[i] = '0;
    kmem[3]  = {4'b0010, 7'h50, 5'd5};
    kmem[5]  = {4'b1000, 7'h11, 5'd3};
    kmem[6]  = {4'b1000, 7'h22, 5'd7};
    kmem[7]  = {4'b0000, 7'h01, 5'd1};
    kmem[8]  = {4'b0011, 7'h02, 5'd2};
    kmem[10] = {4'b0010, 7'h33, 5'd9};
    rst_ni = 1'b0; start_i = '0; ker_id_i = '0; col_done_i = '0;
    tick(2);
    chk_all_zero("reset");
    rst_ni = 1'b1;
    tick(2);

    // Both slots request all four columns; slot 0 wins, slot 1 waits for the release.
    c = cyc;
    push(K_LAUNCH, 4'b1111, 7'h11, 5'd3, c + 5);
    start(2'b11, 4'd5, 4'd6);
    chk("both_busy", 32'(slot_busy_o), 32'd3);
    wait_cyc(c + 2);
    chk("rd_req", 32'(kmem_req_o), 32'd1);
    chk("rd_addr", 32'(kmem_addr_o), 32'd5);
    wait_cyc(c + 10);
    push(K_DONE, 4'b0001, '0, '0, c + 11);
    push(K_LAUNCH, 4'b1111, 7'h22, 5'd7, c + 12);
    cdone(4'b1111);
    wait_cyc(c + 14);
    push(K_DONE, 4'b0010, '0, '0, c + 15);
    cdone(4'b1111);
    wait_cyc(c + 16);
    chk("both_idle", 32'(slot_busy_o), 32'd0);

    // Single two-column kernel; busy-slot start, unowned done and start-on-done are ignored.
    tick(2);
    c = cyc;
    push(K_LAUNCH, 4'b0011, 7'h50, 5'd5, c + 5);
    start(2'b01, 4'd3, 4'd0);
    wait_cyc(c + 2);
    chk("t1_rd_req", 32'(kmem_req_o), 32'd1);
    chk("t1_rd_addr", 32'(kmem_addr_o), 32'd3);
    wait_cyc(c + 6);
    start(2'b01, 4'd5, 4'd0);
    cdone(4'b1000);
    chk("t1_busy_run", 32'(slot_busy_o), 32'd1);
    wait_cyc(c + 9);
    cdone(4'b0001);
    wait_cyc(c + 11);
    push(K_DONE, 4'b0001, '0, '0, c + 12);
    cdone(4'b0010);
    chk("t1_busy_at_done", 32'(slot_busy_o), 32'd0);
    start(2'b01, 4'd3, 4'd0);
    chk("t1_start_on_done", 32'(slot_busy_o), 32'd0);
    tick(8);

    // Malformed column fields: zero, then multi-hot.
    c = cyc;
    push(K_ERR, 4'b0010, '0, '0, c + 4);
    start(2'b10, 4'd0, 4'd7);
    wait_cyc(c + 5);
    chk("err0_busy", 32'(slot_busy_o), 32'd0);
    c = cyc;
    push(K_ERR, 4'b0001, '0, '0, c + 4);
    start(2'b01, 4'd8, 4'd0);
    wait_cyc(c + 5);
    chk("err3_busy", 32'(slot_busy_o), 32'd0);
    tick(2);

    // Fragmented columns: slot 0 keeps cols 1 and 3, slot 1 wants two.
    c0 = cyc;
    push(K_LAUNCH, 4'b1111, 7'h11, 5'd3, c0 + 5);
    start(2'b01, 4'd5, 4'd0);
    wait_cyc(c0 + 7);
    cdone(4'b0101);
    wait_cyc(c0 + 9);
    c = cyc;
`ifdef CGRA_DISPATCH_CONTIG_EN
    push(K_LAUNCH, 4'b1100, 7'h33, 5'd9, c + 8);
    start(2'b10, 4'd0, 4'd10);
    wait_cyc(c + 6);
    cdone(4'b1000);
    wait_cyc(c + 9);
    push(K_DONE, 4'b0001, '0, '0, c + 10);
    cdone(4'b0010);
    wait_cyc(c + 11);
    push(K_DONE, 4'b0010, '0, '0, c + 12);
    cdone(4'b1100);
`else
    push(K_LAUNCH, 4'b0101, 7'h33, 5'd9, c + 5);
    start(2'b10, 4'd0, 4'd10);
    wait_cyc(c + 6);
    cdone(4'b1000);
    wait_cyc(c + 8);
    push(K_DONE, 4'b0001, '0, '0, c + 9);
    cdone(4'b0010);
    wait_cyc(c + 10);
    push(K_DONE, 4'b0010, '0, '0, c + 11);
    cdone(4'b0101);
`endif
    tick(3);
    chk("frag_idle", 32'(slot_busy_o), 32'd0);

    // Reset while slot 1 waits in ALLOC behind slot 0.
    c0 = cyc;
    push(K_LAUNCH, 4'b1111, 7'h11, 5'd3, c0 + 5);
    start(2'b01, 4'd5, 4'd0);
    wait_cyc(c0 + 6);
    c = cyc;
    start(2'b10, 4'd0, 4'd6);
    wait_cyc(c + 6);
    rst_ni = 1'b0;
    tick(1);
    chk_all_zero("midrst");
    rst_ni = 1'b1;
    tick(2);
    cdone(4'b1111);
    tick(15);
    chk("post_rst_busy", 32'(slot_busy_o), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
